ecc_scrubber: RTL and testbench
===============================

Name: ecc_scrubber

Overview:
- Background scrubber between one ECC-protected single-port SRAM bank and the core/interconnect port that owns it.
- On each trigger, it reads one word while the core is idle and checks it through the existing ECC decoder.
- Correctable words are re-encoded and written back; uncorrectable words are reported.
- Core traffic always has priority. The scrubber uses only idle bank cycles.

Parameters:
- BankSize, 256, number of words in the bank (>=2, not necessarily a power of two).
- DataWidth, 32, unencoded data width. Encoded width EW = get_cw_width(DataWidth)+1, i.e. 39 for the default.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- scrub_trigger_i  in  1  request one scrub step; ignored while busy_o=1
- intc_req_i  in  1  core bank request
- intc_we_i  in  1  core write enable
- intc_add_i  in  AW=$clog2(BankSize)  core address
- intc_wdata_i  in  EW  core encoded write data
- intc_rdata_o  out  EW  core read data, combinational passthrough of bank_rdata_i
- bank_req_o  out  1  bank request
- bank_we_o  out  1  bank write enable
- bank_add_o  out  AW  bank address
- bank_wdata_o  out  EW  bank write data
- bank_rdata_i  in  EW  bank read data, valid 1 cycle after a read request
- busy_o  out  1  state != IDLE
- corrected_o  out  1  1-cycle pulse on each completed scrub writeback
- uncorrectable_o  out  1  1-cycle pulse on each double error detected
- pass_done_o  out  1  1-cycle pulse when the scrub address wraps to 0
- corr_count_o  out  16  saturating count of writebacks (feature only)
- uncorr_count_o  out  16  saturating count of double errors (feature only)

Behaviour:
- **Reset:** asynchronous active-low. State=IDLE, scrub_addr=0, all registered outputs and pulses 0. A reset mid-operation aborts the step; no write is issued.
- **Bank mux:** if intc_req_i=1, the bank ports are driven from the intc_* inputs (core always wins). Otherwise the scrubber drives them; bank_req_o=0 when the scrubber has nothing to issue.
- **IDLE:** scrub_trigger_i=1 -> READ.
- **READ:**
  - intc_req_i=0 -> issue read of scrub_addr, go to CHECK.
  - intc_req_i=1 -> stay in READ.
- **CHECK:**
  - bank_rdata_i holds the scrub word and is fed to ecc_decode.
  - single_error or parity_error -> register ecc_encode(decoded data), go to WRITE.
  - double_error -> pulse uncorrectable_o, advance, go to IDLE.
  - no error -> advance, go to IDLE.
- **WRITE:**
  - intc_req_i=0 -> write the registered word to scrub_addr, pulse corrected_o, advance, go to IDLE.
  - intc_req_i=1 -> stay in WRITE.
- **Stale-data abort:** a core write to scrub_addr (intc_req_i & intc_we_i & intc_add_i==scrub_addr) seen in CHECK or in any WRITE cycle sets a stale flag. When stale is set, the writeback is skipped, corrected_o stays 0, the scrubber advances and returns to IDLE. Pulse timing: the stale decision is taken in the cycle the write would have issued.
- **Advance:** scrub_addr += 1. At BankSize-1 it wraps to 0 and pulses pass_done_o in the same cycle.
- **Latency:** with no core traffic, trigger to IDLE is 3 cycles for a clean word and 4 cycles with a writeback.
- **Pulse timing:** pulses last exactly one cycle and are registered, asserted the cycle after the deciding state.

Optional Feature:
- Macro: ECC_SCRUBBER_STATS_EN.
- Defined: two 16-bit counters increment with corrected_o and uncorrectable_o, saturate at 0xFFFF, reset to 0, and drive corr_count_o and uncorr_count_o.
- Undefined: counters are not built; both ports are tied to '0.

Decomposition:
- Add a scrub_state_e enum (IDLE, READ, CHECK, WRITE) to ecc_pkg next to get_parity_width and get_cw_width.
- Instantiate the existing ecc_decode and ecc_encode; no new sub-module.

Test Plan (BankSize=4, DataWidth=32):
- Clean memory, 4 triggers -> reads at addr 0,1,2,3; no bank_we_o; pass_done_o pulses once after the 4th step; scrub_addr back to 0.
- Addr 2 = encode(0xDEADBEEF) with code-word bit 5 flipped, scrub to addr 2 -> one write of encode(0xDEADBEEF) to addr 2; corrected_o pulses once; re-read is clean.
- Addr 1 with bits 3 and 9 flipped -> uncorrectable_o pulses; no write; addr 1 unchanged.
- Trigger with intc_req_i=1 for 10 cycles -> no scrubber bank access until req drops; all core reads/writes pass through bit-exact; the read issues the first idle cycle.
- Single error at addr 0, core writes encode(0x12345678) to addr 0 during CHECK -> no scrub write; corrected_o=0; addr 0 reads encode(0x12345678).
- rst_ni low during WRITE -> bank_we_o never asserted by the scrubber; all outputs 0; scrub_addr=0. With ECC_SCRUBBER_STATS_EN, counters read 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED ECC codec and the background
// scrubber that sits in front of an ECC-protected SRAM bank.
//   get_parity_width(dw) : number of Hamming check bits for dw data bits
//   get_cw_width(dw)     : Hamming code-word width (data + check bits); the
//                          stored word adds one overall-parity bit on top
//   scrub_state_e        : scrubber FSM states
package ecc_pkg;

  // IDLE waits for a trigger, READ waits for a free bank cycle to fetch the
  // word, CHECK inspects the returned word, WRITE waits to put back the fix.
  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    WRITE
  } scrub_state_e;

  // Smallest p with 2^p >= p + dw + 1, so every single-bit position
  // (data or check) gets a distinct non-zero syndrome.
  function automatic int get_parity_width(input int dataWidth);
    int p;
    p = 1;
    while ((1 << p) < (p + dataWidth + 1)) p++;
    return p;
  endfunction

  function automatic int get_cw_width(input int dataWidth);
    return dataWidth + get_parity_width(dataWidth);
  endfunction

endpackage

// File: rtl/ecc_decode.sv
// ecc_decode: SECDED decoder matching ecc_encode.
//   data_i         : encoded word (get_cw_width(DataWidth)+1)
//   data_o         : corrected data
//   single_error_o : one Hamming bit flipped (corrected in data_o)
//   parity_error_o : only the overall-parity bit flipped (data intact)
//   double_error_o : two bits flipped, data_o not trustworthy
module ecc_decode import ecc_pkg::*; #(
  parameter  int DataWidth   = 32,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CodeWidth   = get_cw_width(DataWidth)
) (
  input  logic [CodeWidth:0]   data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 single_error_o,
  output logic                 parity_error_o,
  output logic                 double_error_o
);

  logic [ParityWidth-1:0] syndrome;
  logic                   overall;
  logic                   inRange;
  logic [CodeWidth-1:0]   fixed;

  // The syndrome is the XOR of the positions of all set bits; for a single
  // flip it names the flipped position. Odd overall parity separates a
  // single flip from a double flip. A syndrome pointing past the code word
  // cannot come from one flip, so it is treated as uncorrectable.
  always_comb begin
    int k;
    syndrome = '0;
    k        = 0;
    for (int pos = 1; pos <= CodeWidth; pos++) begin
      if (data_i[pos-1]) syndrome = syndrome ^ ParityWidth'(pos);
    end
    overall = ^data_i;
    inRange = (int'(syndrome) <= CodeWidth);
    fixed   = data_i[CodeWidth-1:0];
    if (overall && (syndrome != '0) && inRange) begin
      fixed[int'(syndrome)-1] = ~fixed[int'(syndrome)-1];
    end
    data_o = '0;
    for (int pos = 1; pos <= CodeWidth; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data_o[k] = fixed[pos-1];
        k++;
      end
    end
  end

  assign single_error_o = overall && (syndrome != '0) && inRange;
  assign parity_error_o = overall && (syndrome == '0);
  assign double_error_o = (!overall && (syndrome != '0)) || (overall && !inRange);

endmodule

// File: rtl/ecc_encode.sv
// ecc_encode: SECDED encoder.
// Code-word bit i holds Hamming position i+1. Check bits sit at the
// power-of-two positions, data bits fill the remaining positions in
// ascending order, and the top bit is the overall parity of the rest.
//   data_i : unencoded data (DataWidth)
//   data_o : encoded word (get_cw_width(DataWidth)+1)
module ecc_encode import ecc_pkg::*; #(
  parameter  int DataWidth   = 32,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CodeWidth   = get_cw_width(DataWidth)
) (
  input  logic [DataWidth-1:0] data_i,
  output logic [CodeWidth:0]   data_o
);

  logic [CodeWidth-1:0] code;

  // Scatter the data bits into the non-power-of-two positions, then fill
  // each check bit with the XOR of every position whose index has that bit
  // set. Check positions are still zero while the sums are formed.
  always_comb begin
    int  k;
    logic par;
    code = '0;
    k    = 0;
    par  = 1'b0;
    for (int pos = 1; pos <= CodeWidth; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code[pos-1] = data_i[k];
        k++;
      end
    end
    for (int j = 0; j < ParityWidth; j++) begin
      par = 1'b0;
      for (int pos = 1; pos <= CodeWidth; pos++) begin
        if (pos[j]) par = par ^ code[pos-1];
      end
      code[(1 << j) - 1] = par;
    end
  end

  assign data_o = {^code, code};

endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber for one ECC-protected single-port SRAM
// bank. Each trigger reads one word during an idle bank cycle, rewrites it
// re-encoded if it had a correctable error, and reports double errors. The
// core port always has priority over the scrubber.
//   scrub_trigger_i          : start one scrub step (ignored while busy_o)
//   intc_req/we/add/wdata_i  : core bank access, intc_rdata_o passes read data
//   bank_req/we/add/wdata_o  : muxed bank access, bank_rdata_i read data
//   busy_o                   : scrubber not idle
//   corrected_o              : pulse per completed writeback
//   uncorrectable_o          : pulse per double error
//   pass_done_o              : pulse when the scrub address wraps to 0
//   corr_count_o/uncorr_count_o : saturating event counters
// Build option: define ECC_SCRUBBER_STATS_EN to build the two counters;
// otherwise the count ports are tied to zero.
module ecc_scrubber import ecc_pkg::*; #(
  parameter  int BankSize  = 256,
  parameter  int DataWidth = 32,
  localparam int AW        = $clog2(BankSize),
  localparam int EW        = get_cw_width(DataWidth) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          scrub_trigger_i,
  input  logic          intc_req_i,
  input  logic          intc_we_i,
  input  logic [AW-1:0] intc_add_i,
  input  logic [EW-1:0] intc_wdata_i,
  output logic [EW-1:0] intc_rdata_o,
  output logic          bank_req_o,
  output logic          bank_we_o,
  output logic [AW-1:0] bank_add_o,
  output logic [EW-1:0] bank_wdata_o,
  input  logic [EW-1:0] bank_rdata_i,
  output logic          busy_o,
  output logic          corrected_o,
  output logic          uncorrectable_o,
  output logic          pass_done_o,
  output logic [15:0]   corr_count_o,
  output logic [15:0]   uncorr_count_o
);

  scrub_state_e state_q, state_d;
  logic [AW-1:0] scrubAddr_q, scrubAddr_d;
  logic [EW-1:0] wbData_q, encWord;
  logic [DataWidth-1:0] decData;
  logic stale_q, stale_d;
  logic corrected_q, uncorr_q, passDone_q;
  logic singleErr, parityErr, doubleErr, needsFix;
  logic scrubRead, doWrite, advance, lastAddr, staleHit;

  ecc_decode #(.DataWidth(DataWidth)) u_decode (
    .data_i         (bank_rdata_i),
    .data_o         (decData),
    .single_error_o (singleErr),
    .parity_error_o (parityErr),
    .double_error_o (doubleErr)
  );

  ecc_encode #(.DataWidth(DataWidth)) u_encode (
    .data_i (decData),
    .data_o (encWord)
  );

  assign needsFix     = singleErr | parityErr;
  assign intc_rdata_o = bank_rdata_i;
  assign busy_o       = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: READ and WRITE stall for as long as the core holds the bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scrub_trigger_i) state_d = READ;
      READ:    if (!intc_req_i) state_d = CHECK;
      CHECK:   state_d = needsFix ? WRITE : IDLE;
      WRITE:   if (!intc_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: scrubber actions for this cycle plus the bank mux. A pending
  // writeback that went stale still leaves WRITE on the first free cycle,
  // it just never drives the bank.
  always_comb begin
    scrubRead = 1'b0;
    doWrite   = 1'b0;
    advance   = 1'b0;
    case (state_q)
      READ:  scrubRead = !intc_req_i;
      CHECK: advance   = !needsFix;
      WRITE: begin
        advance = !intc_req_i;
        doWrite = !intc_req_i && !stale_q;
      end
      default: ;
    endcase
    if (intc_req_i) begin
      bank_req_o   = 1'b1;
      bank_we_o    = intc_we_i;
      bank_add_o   = intc_add_i;
      bank_wdata_o = intc_wdata_i;
    end else begin
      bank_req_o   = scrubRead | doWrite;
      bank_we_o    = doWrite;
      bank_add_o   = scrubAddr_q;
      bank_wdata_o = doWrite ? wbData_q : '0;
    end
  end

  // A core write to the word being scrubbed makes the held correction
  // obsolete; it is flagged from CHECK onwards and cleared at the next READ.
  always_comb begin
    lastAddr    = (scrubAddr_q == AW'(BankSize - 1));
    scrubAddr_d = scrubAddr_q;
    if (advance) scrubAddr_d = lastAddr ? '0 : scrubAddr_q + AW'(1);
    staleHit = intc_req_i && intc_we_i && (intc_add_i == scrubAddr_q) &&
               ((state_q == CHECK) || (state_q == WRITE));
    stale_d  = (state_q == READ) ? 1'b0 : (stale_q | staleHit);
  end

  // Scrub address, held writeback word, stale flag and registered pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scrubAddr_q <= '0;
      wbData_q    <= '0;
      stale_q     <= 1'b0;
      corrected_q <= 1'b0;
      uncorr_q    <= 1'b0;
      passDone_q  <= 1'b0;
    end else begin
      scrubAddr_q <= scrubAddr_d;
      stale_q     <= stale_d;
      if ((state_q == CHECK) && needsFix) wbData_q <= encWord;
      corrected_q <= doWrite;
      uncorr_q    <= (state_q == CHECK) && doubleErr;
      passDone_q  <= advance && lastAddr;
    end
  end

  assign corrected_o     = corrected_q;
  assign uncorrectable_o = uncorr_q;
  assign pass_done_o     = passDone_q;

`ifdef ECC_SCRUBBER_STATS_EN
  logic [15:0] corrCount_q, uncorrCount_q;

  // Event counters follow the pulses and stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corrCount_q   <= '0;
      uncorrCount_q <= '0;
    end else begin
      if (corrected_q && (corrCount_q != 16'hFFFF)) corrCount_q <= corrCount_q + 16'd1;
      if (uncorr_q && (uncorrCount_q != 16'hFFFF)) uncorrCount_q <= uncorrCount_q + 16'd1;
    end
  end

  assign corr_count_o   = corrCount_q;
  assign uncorr_count_o = uncorrCount_q;
`else
  assign corr_count_o   = '0;
  assign uncorr_count_o = '0;
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: directed bench for ecc_scrubber with BankSize=4,
// DataWidth=32 and a behavioural single-port SRAM with one-cycle read data.
// Expected code words come from an independent Hamming reference encoder.
module tb_ecc_scrubber;

`ifdef ECC_SCRUBBER_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        scrub_trigger_i;
  logic        intc_req_i;
  logic        intc_we_i;
  logic [1:0]  intc_add_i;
  logic [38:0] intc_wdata_i;
  logic [38:0] intc_rdata_o;
  logic        bank_req_o;
  logic        bank_we_o;
  logic [1:0]  bank_add_o;
  logic [38:0] bank_wdata_o;
  logic [38:0] bank_rdata_i = '0;
  logic        busy_o;
  logic        corrected_o;
  logic        uncorrectable_o;
  logic        pass_done_o;
  logic [15:0] corr_count_o;
  logic [15:0] uncorr_count_o;

  logic [38:0] mem [4];
  logic        loadEn = 1'b0;
  logic [1:0]  loadAddr = '0;
  logic [38:0] loadData = '0;

  int          checks = 0;
  int          failures = 0;
  int          scrubReads = 0;
  int          scrubWrites = 0;
  int          corrPulses = 0;
  int          uncorrPulses = 0;
  int          passPulses = 0;
  logic [1:0]  lastRdAddr = '0;
  logic [1:0]  lastWrAddr = '0;
  logic [38:0] lastWrData = '0;

  always #5 clk = ~clk;

  ecc_scrubber #(.BankSize(4), .DataWidth(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .scrub_trigger_i (scrub_trigger_i),
    .intc_req_i      (intc_req_i),
    .intc_we_i       (intc_we_i),
    .intc_add_i      (intc_add_i),
    .intc_wdata_i    (intc_wdata_i),
    .intc_rdata_o    (intc_rdata_o),
    .bank_req_o      (bank_req_o),
    .bank_we_o       (bank_we_o),
    .bank_add_o      (bank_add_o),
    .bank_wdata_o    (bank_wdata_o),
    .bank_rdata_i    (bank_rdata_i),
    .busy_o          (busy_o),
    .corrected_o     (corrected_o),
    .uncorrectable_o (uncorrectable_o),
    .pass_done_o     (pass_done_o),
    .corr_count_o    (corr_count_o),
    .uncorr_count_o  (uncorr_count_o)
  );

  // SRAM model plus a monitor of scrubber-owned bank traffic and pulses.
  always @(posedge clk) begin
    if (loadEn) mem[loadAddr] <= loadData;
    else if (bank_req_o) begin
      if (bank_we_o) mem[bank_add_o] <= bank_wdata_o;
      else           bank_rdata_i    <= mem[bank_add_o];
    end
    if (bank_req_o && !intc_req_i) begin
      if (bank_we_o) begin
        scrubWrites <= scrubWrites + 1;
        lastWrAddr  <= bank_add_o;
        lastWrData  <= bank_wdata_o;
      end else begin
        scrubReads <= scrubReads + 1;
        lastRdAddr <= bank_add_o;
      end
    end
    if (corrected_o)     corrPulses   <= corrPulses + 1;
    if (uncorrectable_o) uncorrPulses <= uncorrPulses + 1;
    if (pass_done_o)     passPulses   <= passPulses + 1;
  end

  // Reference encoder: check bits are the XOR of the positions of all set
  // data bits, overall parity on top.
  function automatic logic [38:0] refEncode(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  syn;
    int          k;
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        cw[pos-1] = d[k];
        if (d[k]) syn = syn ^ 6'(pos);
        k++;
      end
    end
    cw[0]  = syn[0];
    cw[1]  = syn[1];
    cw[3]  = syn[2];
    cw[7]  = syn[3];
    cw[15] = syn[4];
    cw[31] = syn[5];
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [1:0] a, input logic [38:0] d);
    loadAddr = a;
    loadData = d;
    loadEn   = 1'b1;
    @(negedge clk);
    loadEn   = 1'b0;
  endtask

  // One trigger, then count negedges until busy_o drops (bounded).
  task automatic applyStimulus(input int budget, output int cycles);
    scrub_trigger_i = 1'b1;
    @(negedge clk);
    scrub_trigger_i = 1'b0;
    cycles = 1;
    while (busy_o && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int          cyc;
    int          readsBefore;
    int          writesBefore;
    logic [38:0] goodWord, flipWord, dblWord, coreWord, newWord, badWord;

    rst_ni = 1'b0;
    scrub_trigger_i = 1'b0;
    intc_req_i = 1'b0;
    intc_we_i = 1'b0;
    intc_add_i = '0;
    intc_wdata_i = '0;

    // Reset state and clean memory image.
    preload(2'd0, refEncode(32'h0000_0000));
    preload(2'd1, refEncode(32'h1111_2222));
    preload(2'd2, refEncode(32'hA5A5_5A5A));
    preload(2'd3, refEncode(32'hFFFF_FFFF));
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_pulses", {corrected_o, uncorrectable_o, pass_done_o}, 3'b000);
    checkOutput("rst_bank_req", bank_req_o, 1'b0);
    checkOutput("rst_counts", {corr_count_o, uncorr_count_o}, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Clean pass over all four words.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(20, cyc);
      checkOutput("clean_latency", cyc, 3);
      checkOutput("clean_read_addr", lastRdAddr, i);
      checkOutput("pass_done_pulse", pass_done_o, (i == 3));
    end
    @(negedge clk);
    checkOutput("pass_done_width", pass_done_o, 1'b0);
    checkOutput("clean_reads", scrubReads, 4);
    checkOutput("clean_writes", scrubWrites, 0);
    checkOutput("pass_count", passPulses, 1);

    // Single error at addr 2 gets written back.
    goodWord = refEncode(32'hDEAD_BEEF);
    flipWord = goodWord;
    flipWord[5] = ~flipWord[5];
    preload(2'd2, flipWord);
    applyStimulus(20, cyc);
    checkOutput("wrap_read_addr", lastRdAddr, 2'd0);
    applyStimulus(20, cyc);
    applyStimulus(20, cyc);
    checkOutput("fix_latency", cyc, 4);
    checkOutput("fix_write_count", scrubWrites, 1);
    checkOutput("fix_write_addr", lastWrAddr, 2'd2);
    checkOutput("fix_write_data", lastWrData, goodWord);
    checkOutput("fix_corrected", corrected_o, 1'b1);
    checkOutput("fix_no_uncorr", uncorrectable_o, 1'b0);
    @(negedge clk);
    checkOutput("fix_corrected_width", corrected_o, 1'b0);
    checkOutput("fix_mem", mem[2], goodWord);
    for (int i = 0; i < 4; i++) applyStimulus(20, cyc);
    checkOutput("reread_addr", lastRdAddr, 2'd2);
    checkOutput("reread_writes", scrubWrites, 1);
    checkOutput("reread_corr_pulses", corrPulses, 1);
    checkOutput("reread_uncorr_pulses", uncorrPulses, 0);

    // Double error at addr 1 is only reported.
    dblWord = refEncode(32'h0BAD_F00D);
    dblWord[3] = ~dblWord[3];
    dblWord[9] = ~dblWord[9];
    preload(2'd1, dblWord);
    applyStimulus(20, cyc);
    applyStimulus(20, cyc);
    applyStimulus(20, cyc);
    checkOutput("dbl_read_addr", lastRdAddr, 2'd1);
    checkOutput("dbl_latency", cyc, 3);
    checkOutput("dbl_uncorr", uncorrectable_o, 1'b1);
    checkOutput("dbl_no_write", scrubWrites, 1);
    checkOutput("dbl_mem", mem[1], dblWord);

    // Core holds the bank for 10 cycles while a step is pending.
    coreWord = refEncode(32'hCAFE_F00D);
    readsBefore = scrubReads;
    scrub_trigger_i = 1'b1;
    intc_req_i = 1'b1;
    intc_we_i = 1'b0;
    intc_add_i = 2'd1;
    intc_wdata_i = '0;
    @(negedge clk);
    scrub_trigger_i = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 4) checkOutput("core_read_back", intc_rdata_o, coreWord);
      intc_we_i    = (k == 2);
      intc_add_i   = (k == 2 || k == 3) ? 2'd3 : 2'(k);
      intc_wdata_i = (k == 2) ? coreWord : refEncode(32'(k) * 32'h0101_0101);
      #1;
      checkOutput("core_passthru", {bank_req_o, bank_we_o, bank_add_o, bank_wdata_o},
                  {1'b1, intc_we_i, intc_add_i, intc_wdata_i});
      @(negedge clk);
    end
    checkOutput("core_busy", busy_o, 1'b1);
    checkOutput("core_no_scrub_read", scrubReads, readsBefore);
    intc_req_i = 1'b0;
    intc_we_i = 1'b0;
    #1;
    checkOutput("first_idle_read", {bank_req_o, bank_we_o, bank_add_o}, {1'b1, 1'b0, 2'd2});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy_o && cyc < 20);
    checkOutput("after_core_latency", cyc, 2);
    checkOutput("after_core_reads", scrubReads, readsBefore + 1);
    checkOutput("core_mem", mem[3], coreWord);

    // Core write to the scrubbed word during CHECK cancels the writeback.
    applyStimulus(20, cyc);
    newWord = refEncode(32'h1234_5678);
    badWord = refEncode(32'h5555_AAAA);
    badWord[12] = ~badWord[12];
    preload(2'd0, badWord);
    writesBefore = scrubWrites;
    scrub_trigger_i = 1'b1;
    @(negedge clk);
    scrub_trigger_i = 1'b0;
    @(negedge clk);
    intc_req_i = 1'b1;
    intc_we_i = 1'b1;
    intc_add_i = 2'd0;
    intc_wdata_i = newWord;
    @(negedge clk);
    intc_req_i = 1'b0;
    intc_we_i = 1'b0;
    #1;
    checkOutput("stale_no_bank_req", bank_req_o, 1'b0);
    checkOutput("stale_busy", busy_o, 1'b1);
    @(negedge clk);
    checkOutput("stale_idle", busy_o, 1'b0);
    checkOutput("stale_no_corrected", corrected_o, 1'b0);
    checkOutput("stale_no_write", scrubWrites, writesBefore);
    checkOutput("stale_mem", mem[0], newWord);
    checkOutput("stats_corr", corr_count_o, StatsOn ? 16'd1 : 16'd0);
    checkOutput("stats_uncorr", uncorr_count_o, StatsOn ? 16'd1 : 16'd0);
    applyStimulus(20, cyc);
    checkOutput("stale_advanced", lastRdAddr, 2'd1);

    // Reset while a writeback is stalled in WRITE.
    badWord = goodWord;
    badWord[20] = ~badWord[20];
    preload(2'd2, badWord);
    writesBefore = scrubWrites;
    scrub_trigger_i = 1'b1;
    @(negedge clk);
    scrub_trigger_i = 1'b0;
    @(negedge clk);
    intc_req_i = 1'b1;
    intc_we_i = 1'b0;
    intc_add_i = 2'd1;
    @(negedge clk);
    checkOutput("rstw_in_write", {busy_o, bank_we_o}, 2'b10);
    @(negedge clk);
    rst_ni = 1'b0;
    intc_req_i = 1'b0;
    #1;
    checkOutput("rstw_bank", {bank_req_o, bank_we_o}, 2'b00);
    checkOutput("rstw_outputs", {busy_o, corrected_o, uncorrectable_o, pass_done_o}, 4'b0000);
    checkOutput("rstw_counts", {corr_count_o, uncorr_count_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstw_no_write", scrubWrites, writesBefore);
    rst_ni = 1'b1;
    @(negedge clk);
    applyStimulus(20, cyc);
    checkOutput("rstw_addr_zero", lastRdAddr, 2'd0);
    checkOutput("rstw_latency", cyc, 3);
    checkOutput("rstw_mem", mem[2], badWord);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
